axi4_sram_slave: RTL
====================

Name: axi4_sram_slave

Overview:
- AXI4 memory slave that sits directly downstream of the AXI4 interconnect, on one slave port (sN_*).
- Consumes the shared s_AW*/s_W*/s_AR* buses plus its own per-slave VALID/READY pair, and returns B and R channels into the interconnect's slave mux.
- Backed by an internal byte-enabled RAM array.
- Independent write and read FSMs, one outstanding transaction per direction, FIXED/INCR/WRAP bursts.

Parameters:
ID_W, 32, AXI ID width
ADDR_W, 64, address width
DATA_W, 32, data width (power of 2, >=8); BYTES = DATA_W/8
MEM_DEPTH, 1024, RAM depth in DATA_W words (power of 2)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWID  in  ID_W  write ID
AWADDR  in  ADDR_W  write start byte address
AWLEN  in  8  beats-1
AWSIZE  in  8  bytes/beat = 2^AWSIZE[2:0], upper bits ignored
AWBURST  in  3  [1:0] used: 00 FIXED, 01 INCR, 10 WRAP
AWVALID / AWREADY  in / out  1  write address handshake
WDATA  in  DATA_W  write data
WSTRB  in  BYTES  byte strobes
WLAST  in  1  last write beat
WVALID / WREADY  in / out  1  write data handshake
BID  out  ID_W  response ID
BRESP  out  2  00 OKAY, 10 SLVERR
BUSER  out  1024  tied 0
BVALID / BREADY  out / in  1  write response handshake
ARID  in  ID_W  read ID
ARADDR  in  ADDR_W  read start byte address
ARLEN  in  8  beats-1
ARSIZE  in  3  bytes/beat = 2^ARSIZE
ARBURST  in  2  as AWBURST[1:0]
ARVALID / ARREADY  in / out  1  read address handshake
RID  out  ID_W  read ID
RDATA  out  DATA_W  read data
RRESP  out  2  00 OKAY, 10 SLVERR
RLAST  out  1  last read beat
RUSER  out  1024  tied 0
RVALID / RREADY  out / in  1  read data handshake

Behaviour:
- Reset (async, ARESETn=0): AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RDATA, RRESP = 0; both FSMs go to IDLE. RAM contents are not reset.
- AWREADY and ARREADY are registered; they rise on the first ACLK edge after ARESETn deasserts.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE: AWREADY=1. On AW handshake, latch ID, address, len, size, burst; clear error flag; beat counter=0; next cycle AWREADY=0, WREADY=1.
  - W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB at the word index and advances the beat address.
  - Error flag sets if WLAST != (beat==len) on any beat.
  - The burst ends on beat==len regardless of WLAST; next cycle WREADY=0, BVALID=1, BID=latched ID, BRESP = error ? 10 : 00.
  - W_RESP: hold BVALID/BID/BRESP stable until BREADY; on the handshake cycle go to W_IDLE, with AWREADY=1 on the next cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On AR handshake, latch fields; the cycle after, RVALID=1 with beat 0 data, RID=latched ID, RRESP=00.
  - R_DATA: RDATA/RLAST/RRESP hold stable while RVALID & !RREADY.
  - On a handshake, the next beat is presented the following cycle with no bubble.
  - RLAST=1 on beat==len. After the last handshake, RVALID=0 and ARREADY=1 the next cycle.
- Beat address (shared rule, both channels):
  - FIXED: constant.
  - INCR: addr + 2^size.
  - WRAP: wraps at a boundary of (len+1)*2^size aligned down from the start address. len must be 1/3/7/15; other WRAP lengths are treated as INCR.
- Word index = addr[log2(MEM_DEPTH)+log2(BYTES)-1 : log2(BYTES)]. Narrow sizes rely on WSTRB for lane selection.
- Write and read run concurrently. A read sampling a word in the same cycle it is written returns the old data.
- AWLOCK/CACHE/PROT/QOS/REGION/USER are not ports; the interconnect-side bits are left unconnected.

Optional Feature:
- Macro: AXI_SRAM_OOR_SLVERR_EN.
- Defined: a byte address >= MEM_DEPTH*BYTES is out of range.
  - Write beat to such an address: suppressed, sets the error flag (BRESP=10).
  - Read beat: RDATA=0, RRESP=10 for that beat.
- Undefined: no range check; upper address bits are ignored (aliasing), and responses are always OKAY unless the WLAST-mismatch error flag is set.

Test Plan:
- INCR write: AWADDR=0x10, AWLEN=3, AWSIZE=2, data 0xA0..0xA3, WSTRB=0xF -> one B beat with BRESP=00, BID=AWID. INCR read of the same -> RDATA 0xA0..0xA3, RLAST only on the 4th beat, RID=ARID.
- WRAP: AWADDR=0x18, len=3, size=2, data 1,2,3,4 -> words 0x18=1, 0x1C=2, 0x10=3, 0x14=4. WRAP read from 0x18 returns 1,2,3,4.
- Strobes: word preloaded 0xFFFFFFFF, write 0x12345678 with WSTRB=0x3 -> readback 0xFFFF5678.
- WLAST asserted early on beat 1 of len=3 -> 4 beats accepted, all written, BRESP=10. Next correct burst -> BRESP=00.
- Read len=7 with RREADY toggling 1/0 each cycle, concurrent with a write burst to another address -> 8 beats in order, stable while stalled, no drop or duplicate; write completes with BRESP=00.
- ARESETn pulsed low mid read burst (beat 3 of 8) -> RVALID=0 immediately. After release, ARREADY=1 on the first edge and a new read completes normally.
- AXI_SRAM_OOR_SLVERR_EN, MEM_DEPTH=1024, DATA_W=32, write to 0x1000:
  - defined -> BRESP=10 and word 0x0 unchanged;
  - undefined -> BRESP=00 and word 0x0 overwritten.

Source files
------------

// File: rtl/axi4_sram_slave.sv
// AXI4 memory slave backed by a byte-enabled RAM, with independent write/read FSMs and one burst in flight per direction.
// Optional build macro AXI_SRAM_OOR_SLVERR_EN: beats beyond MEM_DEPTH*BYTES are dropped/zeroed and flagged SLVERR.
module axi4_sram_slave #(
    parameter int ID_W      = 32,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [7:0]            AWSIZE,
    input  logic [2:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic [1023:0]         BUSER,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ID_W-1:0]       ARID,
    input  logic [ADDR_W-1:0]     ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_W-1:0]       RID,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic [1023:0]         RUSER,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [1:0]            dbg_w_state,
    output logic                  dbg_r_state
);
    localparam int BYTES = DATA_W / 8;
    localparam int BL    = $clog2(BYTES);
    localparam int WL    = $clog2(MEM_DEPTH);

    // Every channel transfers on the rising edge where VALID and READY are both high; VALID never waits on READY.
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA} r_state_e;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                                    input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << size;
        mask = (ADDR_W'({1'b0, len} + 9'd1) << size) - ADDR_W'(1);
        next_addr = addr + step;
        if (burst == 2'b00)
            next_addr = addr;
        else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            next_addr = (addr & ~mask) | ((addr + step) & mask);
    endfunction

    w_state_e          w_state_q, w_state_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d, w_id_q, w_id_d;
    logic [1:0]        bresp_q, bresp_d, w_burst_q, w_burst_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic [2:0]        w_size_q, w_size_d;
    logic              w_err_q, w_err_d, w_we, w_beat_err, w_oor;

    r_state_e          r_state_q, r_state_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, r_word;
    logic [1:0]        rresp_q, rresp_d, r_burst_q, r_burst_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d, r_next, r_fetch;
    logic [7:0]        r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic [2:0]        r_size_q, r_size_d;
    logic              r_oor;

`ifdef AXI_SRAM_OOR_SLVERR_EN
    assign w_oor = |w_addr_q[ADDR_W-1:WL+BL];
    assign r_oor = |r_fetch[ADDR_W-1:WL+BL];
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
`endif

    always_comb begin
        w_state_d = w_state_q;  awready_d = awready_q;  wready_d = wready_q;  bvalid_d = bvalid_q;
        bid_d     = bid_q;      bresp_d   = bresp_q;    w_id_d   = w_id_q;    w_addr_d = w_addr_q;
        w_len_d   = w_len_q;    w_size_d  = w_size_q;   w_burst_d = w_burst_q;
        w_beat_d  = w_beat_q;   w_err_d   = w_err_q;    w_we     = 1'b0;      w_beat_err = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    awready_d = 1'b0;  wready_d  = 1'b1;
                    w_id_d    = AWID;  w_addr_d  = AWADDR;  w_len_d = AWLEN;
                    w_size_d  = AWSIZE[2:0];  w_burst_d = AWBURST[1:0];
                    w_beat_d  = 8'd0;  w_err_d   = 1'b0;    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && wready_q) begin
                    w_beat_err = (WLAST != (w_beat_q == w_len_q)) || w_oor;
                    w_we       = !w_oor;
                    w_err_d    = w_err_q | w_beat_err;
                    // Burst length comes from AWLEN alone; a misplaced WLAST only taints the response.
                    if (w_beat_q == w_len_q) begin
                        wready_d  = 1'b0;  bvalid_d = 1'b1;  bid_d = w_id_q;
                        bresp_d   = (w_err_q || w_beat_err) ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                        w_addr_d = next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                    end
                end
            end
            W_RESP: begin
                if (BREADY && bvalid_q) begin
                    bvalid_d = 1'b0;  awready_d = 1'b1;  w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Fetch address is the AR address on acceptance, otherwise the following beat, so data lands with no bubble.
    assign r_next  = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
    assign r_fetch = (r_state_q == R_IDLE) ? ARADDR : r_next;
    assign r_word  = mem[r_fetch[WL+BL-1:BL]];

    always_comb begin
        r_state_d = r_state_q;  arready_d = arready_q;  rvalid_d = rvalid_q;  rlast_d = rlast_q;
        rid_d     = rid_q;      rdata_d   = rdata_q;    rresp_d  = rresp_q;   r_addr_d = r_addr_q;
        r_len_d   = r_len_q;    r_size_d  = r_size_q;   r_burst_d = r_burst_q; r_beat_d = r_beat_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    arready_d = 1'b0;  rvalid_d = 1'b1;  rid_d = ARID;
                    r_addr_d  = ARADDR;  r_len_d = ARLEN;  r_size_d = ARSIZE;  r_burst_d = ARBURST;
                    r_beat_d  = 8'd0;  rlast_d = (ARLEN == 8'd0);
                    rdata_d   = r_oor ? '0 : r_word;
                    rresp_d   = r_oor ? 2'b10 : 2'b00;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && RREADY) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;  rlast_d = 1'b0;  arready_d = 1'b1;  r_state_d = R_IDLE;
                    end else begin
                        r_beat_d = r_beat_q + 8'd1;
                        r_addr_d = r_next;
                        rlast_d  = (r_beat_q + 8'd1 == r_len_q);
                        rdata_d  = r_oor ? '0 : r_word;
                        rresp_d  = r_oor ? 2'b10 : 2'b00;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;  awready_q <= 1'b0;  wready_q <= 1'b0;  bvalid_q <= 1'b0;
            bid_q     <= '0;      bresp_q   <= 2'b00; w_id_q   <= '0;    w_addr_q <= '0;
            w_len_q   <= '0;      w_size_q  <= '0;    w_burst_q <= '0;   w_beat_q <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;  arready_q <= 1'b0;  rvalid_q <= 1'b0;  rlast_q  <= 1'b0;
            rid_q     <= '0;      rdata_q   <= '0;    rresp_q  <= 2'b00; r_addr_q <= '0;
            r_len_q   <= '0;      r_size_q  <= '0;    r_burst_q <= '0;   r_beat_q <= '0;
        end else begin
            w_state_q <= w_state_d;  awready_q <= awready_d;  wready_q <= wready_d;  bvalid_q <= bvalid_d;
            bid_q     <= bid_d;      bresp_q   <= bresp_d;    w_id_q   <= w_id_d;    w_addr_q <= w_addr_d;
            w_len_q   <= w_len_d;    w_size_q  <= w_size_d;   w_burst_q <= w_burst_d; w_beat_q <= w_beat_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;  arready_q <= arready_d;  rvalid_q <= rvalid_d;  rlast_q  <= rlast_d;
            rid_q     <= rid_d;      rdata_q   <= rdata_d;    rresp_q  <= rresp_d;   r_addr_q <= r_addr_d;
            r_len_q   <= r_len_d;    r_size_q  <= r_size_d;   r_burst_q <= r_burst_d; r_beat_q <= r_beat_d;
        end
    end

    // RAM is never reset; a same-cycle read of a written word sees the old contents.
    always_ff @(posedge ACLK) begin
        if (w_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (WSTRB[b]) mem[w_addr_q[WL+BL-1:BL]][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{AWSIZE[7:3], AWBURST[2]};

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign BUSER   = '0;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RUSER   = '0;
    assign dbg_w_state = w_state_q;
    assign dbg_r_state = r_state_q;
endmodule
